// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-at-a-time memory copy bus initiator
//
// Copies len words from src_addr to dst_addr, one read then one write per word.
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-low
//   start       in   one-cycle request, accepted only in IDLE
//   src_addr    in   first source word address (latched on accept)
//   dst_addr    in   first destination word address (latched on accept)
//   len         in   number of words to copy (latched on accept)
//   read_data   in   bus read return, valid in the second cycle of a read
//   mem_cmd     out  bus command: 00 none, 01 read, 10 write
//   mem_addr    out  bus address
//   write_data  out  internal word buffer
//   busy        out  high while a word is being moved
//   done        out  one-cycle completion pulse
//   words_left  out  remaining word count
module mem_copy_engine #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] read_data,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_left
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_cur;
    logic [AW-1:0] dst_cur;
    logic [LW-1:0] cnt;
    logic [DW-1:0] word_buf;

    logic load;
    logic capture;
    logic advance;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            src_cur  <= '0;
            dst_cur  <= '0;
            cnt      <= '0;
            word_buf <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                src_cur <= src_addr;
                dst_cur <= dst_addr;
                cnt     <= len;
            end
            if (capture) begin
                word_buf <= read_data;
            end
            // Addresses wrap naturally at AW bits; no wrap is flagged.
            if (advance) begin
                src_cur <= src_cur + AW'(1);
                dst_cur <= dst_cur + AW'(1);
                cnt     <= cnt - LW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        mem_cmd   = MNONE;
        mem_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero-length request finishes without touching the bus
                    // or the latched registers.
                    if (len != '0) begin
                        load      = 1'b1;
                        state_nxt = S_RD_A;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_RD_A: begin
                mem_cmd   = MREAD;
                mem_addr  = src_cur;
                busy      = 1'b1;
                state_nxt = S_RD_D;
            end
            S_RD_D: begin
                mem_cmd   = MREAD;
                mem_addr  = src_cur;
                busy      = 1'b1;
                capture   = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                mem_cmd   = MWRITE;
                mem_addr  = dst_cur;
                busy      = 1'b1;
                advance   = 1'b1;
                state_nxt = (cnt == LW'(1)) ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign write_data = word_buf;
    assign words_left = cnt;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int LW    = 9;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] read_data;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_left;

    // Bus slave storage plus a preload port used only while the engine is idle.
    logic [DW-1:0] ram   [MSIZE];
    logic [DW-1:0] model [MSIZE];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .read_data  (read_data),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .words_left (words_left)
    );

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_cmd == 2'b10)
            ram[mem_addr] <= write_data;
        if (mem_cmd == 2'b01)
            read_data <= ram[mem_addr];
    end

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        model[a] = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issues one copy and checks every cycle up to the IDLE cycle after done.
    // poke_c > 0 raises start with unrelated arguments in that cycle.
    // Returns at the negedge of that IDLE cycle so a caller may chain a start.
    task automatic run_copy(input string tag, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input int n, input int poke_c);
        logic [DW-1:0] dq[$];
        logic [AW-1:0] as_, ad_;
        logic [21:0]   got, exp;
        logic [1:0]    ecmd;
        logic [AW-1:0] eaddr;
        logic          ebusy, edone;
        logic [LW-1:0] ewl;
        int            k, ph;
        dq = {};
        for (int i = 0; i < n; i++) begin
            as_ = AW'(int'(s) + i);
            ad_ = AW'(int'(d) + i);
            dq.push_back(model[as_]);
            model[ad_] = model[as_];
        end
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        start    = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3 * n + 2; c++) begin
            k = 0;
            ph = 0;
            if (c <= 3 * n) begin
                k     = (c - 1) / 3;
                ph    = (c - 1) % 3;
                ecmd  = (ph == 2) ? 2'b10 : 2'b01;
                eaddr = (ph == 2) ? AW'(int'(d) + k) : AW'(int'(s) + k);
                ebusy = 1'b1;
                edone = 1'b0;
                ewl   = LW'(n - k);
            end else begin
                ecmd  = 2'b00;
                eaddr = '0;
                ebusy = 1'b0;
                edone = (c == 3 * n + 1);
                ewl   = '0;
            end
            got = {mem_cmd, mem_addr, busy, done, words_left};
            exp = {ecmd, eaddr, ebusy, edone, ewl};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d cmd/addr/busy/done/left: got %h/%h/%b/%b/%0d want %h/%h/%b/%b/%0d",
                         tag, c, mem_cmd, mem_addr, busy, done, words_left,
                         ecmd, eaddr, ebusy, edone, ewl);
            end
            if (c <= 3 * n && ph == 2) begin
                n_checks++;
                if (write_data !== dq[k]) begin
                    n_fail++;
                    $display("FAIL %s word %0d write_data: got %h want %h", tag, k, write_data, dq[k]);
                end
            end
            if (c == poke_c) begin
                start    = 1'b1;
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                len      = LW'($urandom_range(1, 8));
            end else begin
                start = 1'b0;
            end
            if (c < 3 * n + 2) @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < MSIZE; i++) begin
            n_checks++;
            if (ram[i] !== model[i]) begin
                n_fail++;
                $display("FAIL %s ram[%h]: got %h want %h", tag, i, ram[i], model[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        reset    = 1'b0;
        start    = 1'b1;
        src_addr = 9'h010;
        dst_addr = 9'h040;
        len      = 9'd4;
        pre_we   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < MSIZE; i++) begin
            v = DW'($urandom);
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = v;
            model[i] = v;
            @(negedge clk);
            n_checks++;
            if ({mem_cmd, mem_addr, write_data, busy, done, words_left} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: cmd %h addr %h wd %h busy %b done %b left %0d want all 0",
                         i, mem_cmd, mem_addr, write_data, busy, done, words_left);
            end
        end
        pre_we = 1'b0;
        start  = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_cmd, mem_addr, write_data, busy, done, words_left} !== '0) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d: cmd %h addr %h wd %h busy %b done %b left %0d want all 0",
                         i, mem_cmd, mem_addr, write_data, busy, done, words_left);
            end
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] pat [4];
        pat[0] = 16'h00A1;
        pat[1] = 16'h00B2;
        pat[2] = 16'h00C3;
        pat[3] = 16'h00D4;
        for (int i = 0; i < 4; i++) ram_write(AW'(16 + i), pat[i]);
        run_copy("basic", 9'h010, 9'h040, 4, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[64 + i] !== pat[i]) begin
                n_fail++;
                $display("FAIL basic_dst[%0d]: got %h want %h", i, ram[64 + i], pat[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_len0();
        run_copy("len0", AW'($urandom), AW'($urandom), 0, 0);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_copy("wrap", 9'h1FE, 9'h0FE, 3, 0);
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        run_copy("ignore_rdd", 9'h020, 9'h060, 4, 5);
        @(negedge clk);
        run_copy("ignore_done", 9'h030, 9'h070, 3, 10);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_copy("b2b_a", 9'h100, 9'h140, 2, 0);
        run_copy("b2b_b", 9'h150, 9'h180, 3, 0);
        run_copy("b2b_c", 9'h190, 9'h1A0, 1, 0);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [AW-1:0] s, d;
        int            n;
        for (int r = 0; r < 8; r++) begin
            s = AW'($urandom);
            n = $urandom_range(1, 6);
            d = (r % 3 == 0) ? AW'(int'(s) + 1) : AW'($urandom);
            run_copy("random", s, d, n, 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        logic [AW-1:0] s, d;
        logic [DW-1:0] keep2, keep3;
        s = 9'h080;
        d = 9'h0C0;
        keep2 = model[d + 2];
        keep3 = model[d + 3];
        src_addr = s;
        dst_addr = d;
        len      = 9'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 6; c++) @(negedge clk);
        n_checks++;
        if (mem_cmd !== 2'b10 || mem_addr !== AW'(d + 1)) begin
            n_fail++;
            $display("FAIL abort_in_wr: cmd %h addr %h want 2 %h", mem_cmd, mem_addr, AW'(d + 1));
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++;
        if ({mem_cmd, mem_addr, write_data, busy, done, words_left} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: cmd %h addr %h wd %h busy %b done %b left %0d want all 0",
                     mem_cmd, mem_addr, write_data, busy, done, words_left);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || mem_cmd !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cycle %0d: done %b cmd %h busy %b want 0 0 0", i, done, mem_cmd, busy);
            end
        end
        model[d]     = model[s];
        model[d + 1] = model[s + 1];
        n_checks++;
        if (ram[d] !== model[d] || ram[d + 1] !== model[d + 1]) begin
            n_fail++;
            $display("FAIL abort_words12: got %h %h want %h %h", ram[d], ram[d + 1], model[d], model[d + 1]);
        end
        n_checks++;
        if (ram[d + 2] !== keep2 || ram[d + 3] !== keep3) begin
            n_fail++;
            $display("FAIL abort_words34: got %h %h want %h %h", ram[d + 2], ram[d + 3], keep2, keep3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_basic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
